// File: rtl/mem_arbiter.sv
// Multi-port single-memory arbiter: one access per cycle, 1-cycle read latency.
// Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int NUM_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          oor_err
);

  // Handshake: a requester holds req/we/addr/wdata until gnt is seen in that
  // cycle; the access commits on the edge ending the grant cycle.
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [NUM_PORTS-1:0] gnt_c;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 gnt_any;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_any && req[i] && !rst) begin
        gnt_c[i] = 1'b1;
        gnt_idx  = PORT_W'(i);
        gnt_any  = 1'b1;
      end
    end
  end
`else
  logic [PORT_W-1:0] ptr_q, ptr_d;
  int                cand;

  // Search begins at ptr and wraps, so the last winner gets lowest priority.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!gnt_any && req[cand] && !rst) begin
        gnt_c[cand] = 1'b1;
        gnt_idx     = PORT_W'(cand);
        gnt_any     = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PORT_W'(NUM_PORTS - 1)) ptr_d = '0;
      else                                   ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;

  always_comb begin
    sel_we    = we[gnt_idx];
    sel_addr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    mem_idx   = sel_addr[IDX_W-1:0];
  end

  // Memory is deliberately not reset; gnt_any is already forced low in reset.
  always_ff @(posedge clk) begin
    if (gnt_any && sel_we && in_range) mem[mem_idx] <= sel_wdata;
  end

  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 oor_q, oor_d;

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    oor_d    = gnt_any && !in_range;
    if (gnt_any && !sel_we) begin
      rvalid_d = gnt_c;
      rdata_d  = in_range ? mem[mem_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      oor_q    <= oor_d;
    end
  end

  // Masking by rst kills a response whose grant came the cycle before reset.
  assign gnt     = gnt_c;
  assign rvalid  = rst ? '0 : rvalid_q;
  assign rdata   = rst ? '0 : rdata_q;
  assign oor_err = rst ? 1'b0 : oor_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: driver issues directed accesses, monitor
// checks rvalid/rdata/oor_err against an expected queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [15:0] rdata;
  logic        oor_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {due cycle[55:24], rvalid one-hot[23:16], rdata[15:0]}
  logic [55:0] exp_q[$];
  logic [31:0] exp_oor_q[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oor_err(oor_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input string nm, input logic r_rst, input logic [1:0] r,
                      input logic [1:0] w, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] eg, input logic push_rd,
                      input logic [15:0] erd, input logic eoor);
    rst = r_rst; req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    @(negedge clk);
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL %s gnt got %b exp %b", nm, gnt, eg);
    end
    if (push_rd) exp_q.push_back({32'(cyc + 1), 6'b0, eg, erd});
    if (eoor) exp_oor_q.push_back(32'(cyc + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_rdata(input string nm, input logic [15:0] e);
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL %s rdata got %h exp %h", nm, rdata, e);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (gnt !== 2'b00 || rvalid !== 2'b00 || oor_err !== 1'b0 || rdata !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs gnt %b rvalid %b oor %b rdata %h exp all zero",
                 gnt, rvalid, oor_err, rdata);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0][55:24] == 32'(cyc)) begin
        logic [55:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rvalid !== e[17:16] || rdata !== e[15:0]) begin
          errors++;
          $display("FAIL read_resp cyc %0d rvalid %b rdata %h exp rvalid %b rdata %h",
                   cyc, rvalid, rdata, e[17:16], e[15:0]);
        end
      end else if (rvalid !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid cyc %0d rvalid %b exp 00", cyc, rvalid);
      end
      if (exp_oor_q.size() > 0 && exp_oor_q[0] == 32'(cyc)) begin
        void'(exp_oor_q.pop_front());
        checks++;
        if (oor_err !== 1'b1) begin
          errors++;
          $display("FAIL oor_pulse cyc %0d oor_err %b exp 1", cyc, oor_err);
        end
      end else if (oor_err !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_oor cyc %0d oor_err %b exp 0", cyc, oor_err);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step("rst_hold", 1, 2'b01, 2'b01, 16'd3, 16'd0, 16'hDEAD, 16'h0, 2'b00, 0, 16'h0, 0);

    // Single write then read, plus setup writes
    step("wr5",  0, 2'b01, 2'b01, 16'd5, 16'd0, 16'hBEEF, 16'h0, 2'b01, 0, 16'h0, 0);
    step("rd5",  0, 2'b01, 2'b00, 16'd5, 16'd0, 16'h0, 16'h0, 2'b01, 1, 16'hBEEF, 0);
    step("wr6",  0, 2'b10, 2'b10, 16'd0, 16'd6, 16'h0, 16'h6666, 2'b10, 0, 16'h0, 0);
    step("wr3",  0, 2'b01, 2'b01, 16'd3, 16'd0, 16'h1111, 16'h0, 2'b01, 0, 16'h0, 0);
    step("wr0",  0, 2'b10, 2'b10, 16'd0, 16'd0, 16'h0, 16'h5A5A, 2'b10, 0, 16'h0, 0);

    // Read granted right before reset: its response must be suppressed
    step("rd_pre_rst", 0, 2'b01, 2'b00, 16'd6, 16'd0, 16'h0, 16'h0, 2'b01, 0, 16'h0, 0);
    step("rst_mid", 1, 2'b01, 2'b01, 16'd3, 16'd0, 16'hDEAD, 16'h0, 2'b00, 0, 16'h0, 0);
    step("rst_mid", 1, 2'b01, 2'b01, 16'd3, 16'd0, 16'hDEAD, 16'h0, 2'b00, 0, 16'h0, 0);

    // Contention from reset default
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      step("cont_fp", 0, 2'b11, 2'b00, 16'd5, 16'd6, 16'h0, 16'h0, 2'b01, 1, 16'hBEEF, 0);
`else
    for (int i = 0; i < 2; i++) begin
      step("cont_p0", 0, 2'b11, 2'b00, 16'd5, 16'd6, 16'h0, 16'h0, 2'b01, 1, 16'hBEEF, 0);
      step("cont_p1", 0, 2'b11, 2'b00, 16'd5, 16'd6, 16'h0, 16'h0, 2'b10, 1, 16'h6666, 0);
    end
`endif
    step("p1_alone", 0, 2'b10, 2'b00, 16'd5, 16'd6, 16'h0, 16'h0, 2'b10, 1, 16'h6666, 0);

    // Reset neither wrote DEAD nor cleared memory
    step("rd3", 0, 2'b01, 2'b00, 16'd3, 16'd0, 16'h0, 16'h0, 2'b01, 1, 16'h1111, 0);

    // Out of range
    step("oor_wr", 0, 2'b10, 2'b10, 16'd0, 16'h0100, 16'h0, 16'h1234, 2'b10, 0, 16'h0, 1);
    step("oor_rd", 0, 2'b10, 2'b00, 16'd0, 16'h0100, 16'h0, 16'h0, 2'b10, 1, 16'h0000, 1);
    step("rd0",    0, 2'b01, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 2'b01, 1, 16'h5A5A, 0);
    step("idle",   0, 2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0);
    check_rdata("rdata_hold", 16'h5A5A);

    // Write by port0 then read by port1 in the next cycle
    step("fwd_wr", 0, 2'b01, 2'b01, 16'd7, 16'd0, 16'h00AA, 16'h0, 2'b01, 0, 16'h0, 0);
    step("fwd_rd", 0, 2'b10, 2'b00, 16'd0, 16'd7, 16'h0, 16'h0, 2'b10, 1, 16'h00AA, 0);
    step("b2b_rd", 0, 2'b10, 2'b00, 16'd0, 16'd7, 16'h0, 16'h0, 2'b10, 1, 16'h00AA, 0);

    // Top in-range address
    step("wr255", 0, 2'b01, 2'b01, 16'd255, 16'd0, 16'h7777, 16'h0, 2'b01, 0, 16'h0, 0);
    step("rd255", 0, 2'b01, 2'b00, 16'd255, 16'd0, 16'h0, 16'h0, 2'b01, 1, 16'h7777, 0);

    for (int i = 0; i < 3; i++)
      step("drain", 0, 2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0);

    checks++;
    if (exp_q.size() != 0 || exp_oor_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending read %0d oor %0d exp 0 0", exp_q.size(), exp_oor_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
